cam_lookup_responder: RTL

Single-port key/value table that answers the lookup request/response handshake issued by packet handlers, and absorbs table writes on the split index/data update channel. It is the responding end of the handler-side lookup port: a handler drives `req_index`, this block returns `value_data`. It sits beside handler modules as a lightweight stand-in for a multi-port arbiter when exactly one handler owns a table. Entries are fully associative; new keys get the lowest free slot, and a round-robin victim is replaced when the table is full.

---
 rtl/cam_lookup_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cam_lookup_responder.sv
// rtl/cam_lookup_responder.sv - fully associative key/value table answering a lookup request/response port
// Lookups run IDLE->CMP->RESP. Updates latch key and value independently, then commit together.
module cam_lookup_responder #(
  parameter int TABLE_SIZE = 64,
  parameter int KEY_SIZE   = 32,
  parameter int VALUE_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEY_SIZE-1:0]   s_lookup_req_index,
  input  logic                  s_lookup_req_valid,
  output logic                  s_lookup_req_ready,
  output logic [VALUE_SIZE-1:0] s_lookup_value_data,
  output logic                  s_lookup_value_valid,
  input  logic                  s_lookup_value_ready,
  input  logic [KEY_SIZE-1:0]   s_update_req_index,
  input  logic                  s_update_req_index_valid,
  output logic                  s_update_req_index_ready,
  input  logic [VALUE_SIZE-1:0] s_update_req_data,
  input  logic                  s_update_req_data_valid,
  output logic                  s_update_req_data_ready
);

  localparam int IW = $clog2(TABLE_SIZE);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t                state_q;
  logic                  req_ready_q;
  logic                  value_valid_q;
  logic [VALUE_SIZE-1:0] value_data_q;
  logic [KEY_SIZE-1:0]   lk_key_q;

  logic [TABLE_SIZE-1:0] valid_q;
  logic [KEY_SIZE-1:0]   key_q [TABLE_SIZE];
  logic [VALUE_SIZE-1:0] val_q [TABLE_SIZE];
  logic [IW-1:0]         victim_q;
  logic [IW-1:0]         victim_d;

  logic                  uk_full_q;
  logic                  ud_full_q;
  logic [KEY_SIZE-1:0]   uk_q;
  logic [VALUE_SIZE-1:0] ud_q;

  logic                  commit;
  logic                  match_f;
  logic                  free_f;
  logic [IW-1:0]         match_idx;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         tgt_idx;
  logic [VALUE_SIZE-1:0] hit_val;

  assign commit = uk_full_q && ud_full_q;

  // Scanning downward leaves the lowest matching index as the winner.
  always_comb begin
    hit_val = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == lk_key_q) hit_val = val_q[i];
    end
  end

  always_comb begin
    match_f   = 1'b0;
    free_f    = 1'b0;
    match_idx = '0;
    free_idx  = '0;
    for (int i = TABLE_SIZE - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == uk_q) begin
        match_f   = 1'b1;
        match_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_f   = 1'b1;
        free_idx = IW'(i);
      end
    end
    victim_d = victim_q;
    if (match_f) begin
      tgt_idx = match_idx;
    end else if (free_f) begin
      tgt_idx = free_idx;
    end else begin
      tgt_idx  = victim_q;
      victim_d = victim_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      value_valid_q <= 1'b0;
      value_data_q  <= '0;
      lk_key_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_lookup_req_valid && req_ready_q) begin
            lk_key_q    <= s_lookup_req_index;
            req_ready_q <= 1'b0;
            state_q     <= CMP;
          end
        end
        CMP: begin
          value_data_q  <= hit_val;
          value_valid_q <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (s_lookup_value_ready) begin
            value_valid_q <= 1'b0;
            req_ready_q   <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          req_ready_q   <= 1'b1;
          value_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uk_full_q <= 1'b0;
      ud_full_q <= 1'b0;
      valid_q   <= '0;
      victim_q  <= '0;
    end else if (commit) begin
      uk_full_q        <= 1'b0;
      ud_full_q        <= 1'b0;
      valid_q[tgt_idx] <= 1'b1;
      victim_q         <= victim_d;
    end else begin
      if (s_update_req_index_valid && !uk_full_q) uk_full_q <= 1'b1;
      if (s_update_req_data_valid && !ud_full_q)  ud_full_q <= 1'b1;
    end
  end

  // Keys, values and holding registers carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (s_update_req_index_valid && !uk_full_q) uk_q <= s_update_req_index;
    if (s_update_req_data_valid && !ud_full_q)  ud_q <= s_update_req_data;
    if (commit) begin
      key_q[tgt_idx] <= uk_q;
      val_q[tgt_idx] <= ud_q;
    end
  end

  assign s_lookup_req_ready       = req_ready_q;
  assign s_lookup_value_valid     = value_valid_q;
  assign s_lookup_value_data      = value_data_q;
  assign s_update_req_index_ready = !uk_full_q;
  assign s_update_req_data_ready  = !ud_full_q;

endmodule
